// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and default sizing.
package freq_meter_pkg;

    typedef enum logic {
        ST_ARM  = 1'b0,
        ST_MEAS = 1'b1
    } fm_state_e;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Synchroniser for an asynchronous input followed by a registered rising-edge detector.
module sync_edge
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic C,
    input  logic CLR_N,
    input  logic D,
    output logic RISE
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;

    // The rise is registered so the count lands SYNC_STAGES+1 cycles after sampling.
    always_ff @(posedge C) begin
        if (!CLR_N) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

    assign RISE = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of SIG_IN between consecutive CE ticks and presents the held
// result with a one-cycle VALID strobe; the first window after reset is discarded.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic             SIG_IN,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    fm_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             rise;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .C    (C),
        .CLR_N(CLR_N),
        .D    (SIG_IN),
        .RISE (rise)
    );

    always_ff @(posedge C) begin
        if (!CLR_N) begin
            state_q   <= ST_ARM;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            q_q       <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            q_q       <= q_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        q_d       = q_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        if (CE) begin
            // An edge coinciding with CE opens the new window rather than closing the old one.
            if (state_q == ST_MEAS) begin
                q_d     = cnt_q;
                ovf_d   = ovf_acc_q;
                valid_d = 1'b1;
            end
            cnt_d     = {{(WIDTH-1){1'b0}}, rise};
            ovf_acc_d = 1'b0;
            state_d   = ST_MEAS;
        end else if (rise) begin
            if (cnt_q == CNT_MAX) begin
                ovf_acc_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign OVF   = ovf_q;

endmodule
